mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory interface between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Captures the winning request, runs one memory transaction, registers the result and returns a one-cycle ready pulse to the owner.
- Sits between the fetch/LSU request buses and the memory interface (`mem_req`/`mem_ready` handshake).

Parameters:
- M_WIDTH, 8, address and data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request (level, held until if_ready).
- if_addr  in  M_WIDTH  fetch address.
- if_ready  out  1  one-cycle pulse: if_data valid.
- if_data  out  M_WIDTH  registered read data to fetch.
- ls_req  in  1  LSU request (level, held until ls_ready).
- ls_we  in  1  LSU write enable (1 = write).
- ls_addr  in  M_WIDTH  LSU address.
- ls_wdata  in  M_WIDTH  LSU write data.
- ls_ready  out  1  one-cycle pulse: LSU transaction complete, ls_data valid on reads.
- ls_data  out  M_WIDTH  registered read data to LSU.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  M_WIDTH  memory address.
- mem_wdata  out  M_WIDTH  memory write data.
- mem_rdata  in  M_WIDTH  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion pulse.

Behaviour:
- States:
  - IDLE: no transaction in progress.
  - BUSY: transaction issued to memory.
  - DONE: completion reported to the owner.
- Registers: owner (0 = fetch, 1 = LSU), and latched addr/wdata/we.
- Reset (async, rst_n = 0):
  - state = IDLE; owner = 0.
  - mem_req = mem_we = 0; mem_addr = mem_wdata = 0.
  - if_ready = ls_ready = 0; if_data = ls_data = 0.
  - Priority pointer = fetch.
- IDLE:
  - If any request is present, pick a winner per the priority rule.
  - Latch the winner's address, wdata and we. Fetch forces we = 0 and wdata = 0.
  - Set owner and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_req = 1; mem_addr, mem_wdata and mem_we are driven from the latched registers. All are stable for the whole state.
  - On mem_ready: capture mem_rdata into the owner's data register (reads only; on writes the data register is unchanged) and go to DONE.
- DONE:
  - Owner's ready = 1 for exactly this cycle; mem_req = 0.
  - Go to IDLE next cycle. The requester drops its req during this cycle.
- Latency: request sampled at edge N → mem_req high from cycle N+1 → mem_ready at edge M → ready high for cycle M+1. Minimum round trip is 3 cycles from request to ready.
- Priority without the macro: fixed, LSU over fetch.
- Requester drops req during BUSY: the transaction still completes and ready still pulses. Requester inputs are ignored outside IDLE.
- mem_ready outside BUSY: ignored.
- Non-owner data register holds its value; non-owner ready stays 0.
- Reset mid-BUSY: immediate return to IDLE; mem_req drops asynchronously. The in-flight result is discarded.
- mem_req, mem_* and the ready outputs are all registered or decoded from registered state only. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer marks the preferred requester.
  - On simultaneous requests the pointer's side wins.
  - After every grant the pointer flips to the other requester.
  - A single requester always wins regardless of the pointer.
  - Reset value of the pointer = fetch.
- Undefined: fixed LSU-over-fetch priority; no pointer register.

Test Plan:
- Single fetch:
  - Stimulus: if_req = 1, if_addr = 0x10; memory returns 0xA5 with mem_ready two cycles after mem_req rises.
  - Required: mem_addr = 0x10, mem_we = 0; if_data = 0xA5; if_ready pulses once, exactly one cycle after mem_ready; ls_ready stays 0.
- LSU write:
  - Stimulus: ls_req = 1, ls_we = 1, ls_addr = 0x80, ls_wdata = 0x3C.
  - Required: mem_we = 1, mem_addr = 0x80, mem_wdata = 0x3C held until mem_ready; ls_ready pulses; ls_data unchanged.
- Simultaneous requests, fixed priority:
  - Stimulus: if_req and ls_req asserted together (fetch 0x01, LSU read 0x02, rdata 0x11 then 0x22); each requester drops its req in the DONE cycle.
  - Required: LSU serviced first (ls_data = 0x11), then fetch (if_data = 0x22). With MEM_ARB_RR_EN defined: fetch first, then LSU, then alternating on continuous contention over 4 grants.
- Address stability:
  - Stimulus: change if_addr from 0x10 to 0x20 while in BUSY.
  - Required: mem_addr stays 0x10 until mem_ready.
- Reset mid-transaction:
  - Stimulus: drop rst_n during BUSY, before mem_ready.
  - Required: mem_req = 0 immediately, no ready pulse; after release, a new fetch request at 0x05 completes normally.
- Stray mem_ready:
  - Stimulus: pulse mem_ready while in IDLE.
  - Required: no state change, both ready outputs stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Function : Shares one memory port between the fetch unit (read-only) and
//            the load/store unit (read/write). It latches the winning
//            request, runs one memory transaction, registers the read data
//            and pulses the owner's ready for one cycle.
// Options  : MEM_ARB_RR_EN - when defined, simultaneous requests are
//            arbitrated round-robin (pointer resets to fetch). When it is
//            undefined, LSU has fixed priority over fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int M_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  // fetch side
  input  logic               if_req,
  input  logic [M_WIDTH-1:0] if_addr,
  output logic               if_ready,
  output logic [M_WIDTH-1:0] if_data,
  // load/store side
  input  logic               ls_req,
  input  logic               ls_we,
  input  logic [M_WIDTH-1:0] ls_addr,
  input  logic [M_WIDTH-1:0] ls_wdata,
  output logic               ls_ready,
  output logic [M_WIDTH-1:0] ls_data,
  // memory side
  output logic               mem_req,
  output logic               mem_we,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic [M_WIDTH-1:0] mem_wdata,
  input  logic [M_WIDTH-1:0] mem_rdata,
  input  logic               mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;      // 0 = fetch, 1 = LSU
  logic               we_q, we_d;
  logic [M_WIDTH-1:0] addr_q, addr_d;
  logic [M_WIDTH-1:0] wdata_q, wdata_d;
  logic [M_WIDTH-1:0] if_data_q, if_data_d;
  logic [M_WIDTH-1:0] ls_data_q, ls_data_d;

  // Winner of the current IDLE-cycle arbitration (1 = LSU).
  logic               grant_ls;
  logic               any_req;

  assign any_req = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: marks the requester preferred on contention (1 = LSU).
  logic rr_ptr_q, rr_ptr_d;

  // Contention goes to the pointer's side; a lone requester always wins.
  always_comb begin
    grant_ls = ls_req;
    if (if_req && ls_req) begin
      grant_ls = rr_ptr_q;
    end
  end

  // After every grant the preference moves to the requester that did not win.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == IDLE) && any_req) begin
      rr_ptr_d = ~grant_ls;
    end
  end

  // Pointer register, resets to prefer fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: LSU wins whenever it requests.
  always_comb begin
    grant_ls = ls_req;
  end
`endif

  // Next-state and datapath capture for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    ls_data_d = ls_data_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant_ls;
          state_d = BUSY;
          if (grant_ls) begin
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            we_d    = ls_we;
          end else begin
            // Fetch is read-only: write strobe and data are forced low.
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end

      BUSY: begin
        if (mem_ready) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) begin
              ls_data_d = mem_rdata;
            end else begin
              if_data_d = mem_rdata;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      ls_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      ls_data_q <= ls_data_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  // combinationally. The write strobe is qualified with BUSY so it never
  // lingers after a write completes.
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = (state_q == DONE) & ~owner_q;
  assign ls_ready  = (state_q == DONE) &  owner_q;
  assign if_data   = if_data_q;
  assign ls_data   = ls_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Function : Self-checking bench for mem_arbiter. Directed scenarios followed
//            by randomized traffic, checked against a transaction-level model
//            (winner choice, latched request, returned data per requester).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int W = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_ready;
  logic [W-1:0] if_data;
  logic         ls_req;
  logic         ls_we;
  logic [W-1:0] ls_addr;
  logic [W-1:0] ls_wdata;
  logic         ls_ready;
  logic [W-1:0] ls_data;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  mem_arbiter #(.M_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_ready  (ls_ready),
    .ls_data   (ls_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: preferred side on contention and each requester's
  // last delivered read data.
  bit           m_ptr_ls;
  logic [W-1:0] m_if_data;
  logic [W-1:0] m_ls_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr_ls  = 1'b0;
    m_if_data = '0;
    m_ls_data = '0;
  endtask

  // Run one full transaction from IDLE with the requests currently driven.
  // lat    : BUSY cycles before the one in which mem_ready is given
  // stray  : also assert mem_ready on the edge that samples the request
  // perturb: change requester inputs during BUSY (must be ignored)
  // drop   : winner drops its request during BUSY (must still complete)
  task automatic do_grant(input int lat, input logic [W-1:0] rdata,
                          input bit perturb, input bit drop, input bit stray);
    bit           win_ls;
    bit           ewe;
    logic [W-1:0] ea;
    logic [W-1:0] ew;
    if (if_req && ls_req) win_ls = RR ? m_ptr_ls : 1'b1;
    else                  win_ls = ls_req;
    if (win_ls) begin
      ea = ls_addr; ew = ls_wdata; ewe = ls_we;
    end else begin
      ea = if_addr; ew = '0;       ewe = 1'b0;
    end
    m_ptr_ls = !win_ls;

    if (stray) begin
      mem_ready = 1'b1;
      mem_rdata = ~rdata;
    end
    tick();
    mem_ready = 1'b0;

    for (int c = 0; c <= lat; c++) begin
      chk("busy_mem_req",   mem_req,   1);
      chk("busy_mem_addr",  mem_addr,  ea);
      chk("busy_mem_we",    mem_we,    ewe);
      chk("busy_mem_wdata", mem_wdata, ew);
      chk("busy_readies",   {if_ready, ls_ready}, 0);
      if (c == 0 && perturb) begin
        if_addr  = if_addr ^ 8'h30;
        ls_addr  = ls_addr ^ 8'h5A;
        ls_wdata = ~ls_wdata;
        ls_we    = ~ls_we;
      end
      if (c == 0 && drop) begin
        if (win_ls) ls_req = 1'b0;
        else        if_req = 1'b0;
      end
      if (c == lat) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = W'($urandom);

    if (!ewe) begin
      if (win_ls) m_ls_data = rdata;
      else        m_if_data = rdata;
    end
    chk("done_if_ready", if_ready, !win_ls);
    chk("done_ls_ready", ls_ready, win_ls);
    chk("done_mem_req",  mem_req,  0);
    chk("done_if_data",  if_data,  m_if_data);
    chk("done_ls_data",  ls_data,  m_ls_data);
    if (win_ls) ls_req = 1'b0;
    else        if_req = 1'b0;
    tick();
    chk("idle_readies", {if_ready, ls_ready}, 0);
    chk("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();

    // Reset state
    tick();
    tick();
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_readies",   {if_ready, ls_ready}, 0);
    chk("rst_if_data",   if_data,   0);
    chk("rst_ls_data",   ls_data,   0);
    rst_n = 1'b1;
    tick();

    // Stray mem_ready while idle
    mem_ready = 1'b1;
    mem_rdata = 8'hFF;
    tick();
    mem_ready = 1'b0;
    chk("stray_mem_req", mem_req, 0);
    chk("stray_readies", {if_ready, ls_ready}, 0);
    chk("stray_if_data", if_data, 0);
    chk("stray_ls_data", ls_data, 0);
    tick();
    chk("stray_still_idle", {mem_req, if_ready, ls_ready}, 0);

    // Single fetch, address changed 0x10 -> 0x20 during BUSY
    if_req  = 1'b1;
    if_addr = 8'h10;
    do_grant(2, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("fetch_if_data", if_data, 8'hA5);

    // LSU write
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h80; ls_wdata = 8'h3C;
    do_grant(1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("write_ls_data_kept", ls_data, 0);

    // Simultaneous requests
    if_req = 1'b1; if_addr = 8'h01;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h02;
    do_grant(1, 8'h11, 1'b0, 1'b0, 1'b0);
    do_grant(1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("sim_ls_data", ls_data, RR ? 8'h22 : 8'h11);
    chk("sim_if_data", if_data, RR ? 8'h11 : 8'h22);

    // Continuous contention over four grants, then drain
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1;
      ls_req = 1'b1;
      do_grant(k % 3, W'($urandom), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      if (if_req || ls_req) do_grant(0, W'($urandom), 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of BUSY
    if_req  = 1'b1;
    if_addr = 8'h33;
    tick();
    chk("pre_rst_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    if_req = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_hold_readies", {if_ready, ls_ready, mem_req}, 0);
    end
    chk("rst_mid_if_data", if_data, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {if_ready, ls_ready, mem_req}, 0);
    if_req  = 1'b1;
    if_addr = 8'h05;
    do_grant(1, 8'h5E, 1'b0, 1'b0, 1'b0);
    chk("post_rst_if_data", if_data, 8'h5E);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      if (!if_req && ($urandom % 2 == 0)) begin
        if_req  = 1'b1;
        if_addr = W'($urandom);
      end
      if (!ls_req && ($urandom % 2 == 0)) begin
        ls_req   = 1'b1;
        ls_we    = 1'($urandom);
        ls_addr  = W'($urandom);
        ls_wdata = W'($urandom);
      end
      if (!if_req && !ls_req) begin
        mem_ready = 1'($urandom);
        tick();
        mem_ready = 1'b0;
        chk("rand_idle", {if_ready, ls_ready, mem_req}, 0);
      end else begin
        do_grant(int'($urandom % 4), W'($urandom), ($urandom % 4) == 0,
                 ($urandom % 6) == 0, ($urandom % 5) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
